// File: rtl/wq_fetch_arbiter_if.sv
// Fetch request/return bundle between the wave-queue fetch arbiter (master)
// and the instruction fetch unit (slave).
interface wq_fetch_arbiter_if;
   logic       fetch_valid;
   logic [5:0] fetch_wf_id;
   logic       fetch_ready;
   logic       fetch_ret_valid;
   logic [5:0] fetch_ret_wf_id;

   modport master (
      output fetch_valid, fetch_wf_id,
      input  fetch_ready, fetch_ret_valid, fetch_ret_wf_id
   );

   modport slave (
      input  fetch_valid, fetch_wf_id,
      output fetch_ready, fetch_ret_valid, fetch_ret_wf_id
   );
endinterface

// File: rtl/wq_fetch_arbiter.sv
// Round-robin fetch arbiter over wavefront slots with one fetch in flight per slot
// and a global outstanding cap. Define WQ_FETCH_ARB_PERF_EN to add perf counters.
module wq_fetch_arbiter #(
   parameter int NUM_WF          = 40,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                clk,
   input  logic                rst,
   wq_fetch_arbiter_if.master  fetch_if,
   input  logic [NUM_WF-1:0]   wf_valid,
   input  logic [NUM_WF-1:0]   stop_fetch,
   output logic [NUM_WF-1:0]   q_vtail_incr,
   output logic [3:0]          outstanding,
   output logic                err_spurious_ret
`ifdef WQ_FETCH_ARB_PERF_EN
   ,
   output logic [31:0]         perf_grants,
   output logic [31:0]         perf_cap_stalls
`endif
);

   typedef enum logic {IDLE, REQ} state_t;

   state_t              state_q;
   logic                fetch_valid_q;
   logic [5:0]          fetch_wf_id_q;
   logic [5:0]          last_grant_q;
   logic [NUM_WF-1:0]   pending_q, pending_d;
   logic [NUM_WF-1:0]   q_vtail_q;
   logic [3:0]          outstanding_q, outstanding_d;
   logic                err_q;

   logic [NUM_WF-1:0]   eligible;
   logic                pick_found;
   logic [5:0]          pick_id;
   logic                hs;
   logic                ret_in_range;
   logic                ret_hit;
   logic                cap_ok;
   logic [NUM_WF-1:0]   grant_onehot;

   function automatic logic [5:0] rr_idx(input logic [5:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_WF) s = s - NUM_WF;
      return 6'(s);
   endfunction

   assign eligible     = wf_valid & ~stop_fetch & ~pending_q;
   assign hs           = fetch_valid_q & fetch_if.fetch_ready;
   assign ret_in_range = int'(fetch_if.fetch_ret_wf_id) < NUM_WF;
   assign ret_hit      = fetch_if.fetch_ret_valid & ret_in_range
                         & pending_q[fetch_if.fetch_ret_wf_id];
   assign cap_ok       = int'(outstanding_q) < MAX_OUTSTANDING;
   assign grant_onehot = {{(NUM_WF-1){1'b0}}, 1'b1} << fetch_wf_id_q;

   // Search starts one past the last grant so every slot gets a turn.
   always_comb begin
      // NOTE: defaults first so no path through the loop can infer a latch.
      pick_found = 1'b0;
      pick_id    = '0;
      for (int off = 1; off <= NUM_WF; off++) begin
         if (!pick_found && eligible[rr_idx(last_grant_q, off)]) begin
            pick_found = 1'b1;
            pick_id    = rr_idx(last_grant_q, off);
         end
      end
   end

   // A same-slot return is never a hit (pending is clear while in REQ), so the set wins.
   always_comb begin
      pending_d = pending_q;
      if (ret_hit) pending_d[fetch_if.fetch_ret_wf_id] = 1'b0;
      if (hs)      pending_d[fetch_wf_id_q]            = 1'b1;
      outstanding_d = outstanding_q;
      case ({hs, ret_hit})
         2'b10:   outstanding_d = outstanding_q + 4'd1;
         2'b01:   outstanding_d = outstanding_q - 4'd1;
         default: outstanding_d = outstanding_q;
      endcase
   end

   // NOTE: non-blocking assignments keep every register update order-independent.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         fetch_valid_q <= 1'b0;
         fetch_wf_id_q <= '0;
         last_grant_q  <= 6'(NUM_WF - 1);
         pending_q     <= '0;
         q_vtail_q     <= '0;
         outstanding_q <= '0;
         err_q         <= 1'b0;
      end else begin
         pending_q     <= pending_d;
         outstanding_q <= outstanding_d;
         q_vtail_q     <= '0;
         if (fetch_if.fetch_ret_valid && !ret_hit) err_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (pick_found && cap_ok) begin
                  fetch_valid_q <= 1'b1;
                  fetch_wf_id_q <= pick_id;
                  state_q       <= REQ;
               end
            end
            REQ: begin
               if (fetch_if.fetch_ready) begin
                  fetch_valid_q <= 1'b0;
                  last_grant_q  <= fetch_wf_id_q;
                  q_vtail_q     <= grant_onehot;
                  state_q       <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef WQ_FETCH_ARB_PERF_EN
   logic [31:0] perf_grants_q;
   logic [31:0] perf_cap_stalls_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_grants_q     <= '0;
         perf_cap_stalls_q <= '0;
      end else begin
         if (hs) perf_grants_q <= perf_grants_q + 32'd1;
         if (state_q == IDLE && pick_found && !cap_ok)
            perf_cap_stalls_q <= perf_cap_stalls_q + 32'd1;
      end
   end

   assign perf_grants     = perf_grants_q;
   assign perf_cap_stalls = perf_cap_stalls_q;
`endif

   assign fetch_if.fetch_valid = fetch_valid_q;
   assign fetch_if.fetch_wf_id = fetch_wf_id_q;
   assign q_vtail_incr         = q_vtail_q;
   assign outstanding          = outstanding_q;
   assign err_spurious_ret     = err_q;

endmodule

// File: tb/tb_wq_fetch_arbiter.sv
// Directed self-checking bench for wq_fetch_arbiter (default 40 slots, cap of 4).
module tb_wq_fetch_arbiter;

   localparam int NUM_WF = 40;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NUM_WF-1:0] wf_valid;
   logic [NUM_WF-1:0] stop_fetch;
   logic [NUM_WF-1:0] q_vtail_incr;
   logic [3:0]        outstanding;
   logic              err_spurious_ret;
`ifdef WQ_FETCH_ARB_PERF_EN
   logic [31:0]       perf_grants;
   logic [31:0]       perf_cap_stalls;
`endif

   logic       man_v = 1'b0;
   logic [5:0] man_id = '0;
   logic       auto_v = 1'b0;
   logic [5:0] auto_id = '0;
   logic       auto_ret_en = 1'b0;
   logic       auto_armed = 1'b0;
   logic [5:0] armed_id = '0;

   int n_checks = 0;
   int n_errors = 0;

   wq_fetch_arbiter_if ifc ();

   assign ifc.fetch_ret_valid = auto_v | man_v;
   assign ifc.fetch_ret_wf_id = auto_v ? auto_id : man_id;

   wq_fetch_arbiter #(.NUM_WF(NUM_WF), .MAX_OUTSTANDING(4)) dut (
      .clk              (clk),
      .rst              (rst),
      .fetch_if         (ifc),
      .wf_valid         (wf_valid),
      .stop_fetch       (stop_fetch),
      .q_vtail_incr     (q_vtail_incr),
      .outstanding      (outstanding),
      .err_spurious_ret (err_spurious_ret)
`ifdef WQ_FETCH_ARB_PERF_EN
      ,
      .perf_grants      (perf_grants),
      .perf_cap_stalls  (perf_cap_stalls)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] onehot_idx(input logic [NUM_WF-1:0] v);
      logic [5:0] r;
      r = '0;
      for (int i = 0; i < NUM_WF; i++) if (v[i]) r = 6'(i);
      return r;
   endfunction

   // Returns each granted slot one cycle after its q_vtail_incr pulse.
   always @(negedge clk) begin
      auto_v     = auto_armed;
      auto_id    = armed_id;
      auto_armed = auto_ret_en && (q_vtail_incr != '0);
      armed_id   = onehot_idx(q_vtail_incr);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst             = 1'b0;
      ifc.fetch_ready = 1'b0;
      man_v           = 1'b0;
      wf_valid        = '0;
      stop_fetch      = '0;
      auto_ret_en     = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      @(negedge clk);
      while (!ifc.fetch_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({tag, " valid"}, 64'(ifc.fetch_valid), 64'd1);
   endtask

   // Caller holds fetch_ready=1, so the handshake lands on the next edge.
   task automatic expect_grant(input string tag, input int exp_id);
      wait_valid(tag);
      check({tag, " id"}, 64'(ifc.fetch_wf_id), 64'(exp_id));
      @(negedge clk);
      check({tag, " vtail"}, 64'(q_vtail_incr), 64'd1 << exp_id);
   endtask

   initial begin
      wf_valid        = '0;
      stop_fetch      = '0;
      ifc.fetch_ready = 1'b0;
      #1;

      // Reset values
      rst = 1'b0;
      #2;
      check("rst valid", 64'(ifc.fetch_valid), 64'd0);
      check("rst id", 64'(ifc.fetch_wf_id), 64'd0);
      check("rst vtail", 64'(q_vtail_incr), 64'd0);
      check("rst outstanding", 64'(outstanding), 64'd0);
      check("rst err", 64'(err_spurious_ret), 64'd0);
      do_reset();

      // 1: three live slots, returns follow each grant
      wf_valid        = 40'h7;
      ifc.fetch_ready = 1'b1;
      auto_ret_en     = 1'b1;
      expect_grant("t1 g0", 0);
      expect_grant("t1 g1", 1);
      expect_grant("t1 g2", 2);
      expect_grant("t1 g3", 0);
      expect_grant("t1 g4", 1);
      expect_grant("t1 g5", 2);
      wf_valid = '0;
      repeat (3) @(negedge clk);
      check("t1 drained", 64'(outstanding), 64'd0);
      check("t1 err", 64'(err_spurious_ret), 64'd0);

      // 2: cap of 4 with no returns
      do_reset();
      wf_valid        = '1;
      ifc.fetch_ready = 1'b1;
      expect_grant("t2 g0", 0);
      expect_grant("t2 g1", 1);
      expect_grant("t2 g2", 2);
      expect_grant("t2 g3", 3);
      begin
         logic seen = 1'b0;
         repeat (5) begin
            @(negedge clk);
            if (ifc.fetch_valid) seen = 1'b1;
         end
         check("t2 capped valid", 64'(seen), 64'd0);
      end
      check("t2 outstanding", 64'(outstanding), 64'd4);
`ifdef WQ_FETCH_ARB_PERF_EN
      check("t2 perf grants", 64'(perf_grants), 64'd4);
      check("t2 perf stalls", 64'(perf_cap_stalls != 0), 64'd1);
`endif
      man_id = 6'd2;
      man_v  = 1'b1;
      @(negedge clk);
      man_v = 1'b0;
      check("t2 after ret", 64'(outstanding), 64'd3);
      expect_grant("t2 g4", 4);
      check("t2 outstanding again", 64'(outstanding), 64'd4);

      // 3: request held through backpressure while stop_fetch toggles
      do_reset();
      wf_valid = 40'(1) << 5;
      wait_valid("t3");
      for (int i = 0; i < 6; i++) begin
         check($sformatf("t3 hold valid c%0d", i), 64'(ifc.fetch_valid), 64'd1);
         check($sformatf("t3 hold id c%0d", i), 64'(ifc.fetch_wf_id), 64'd5);
         stop_fetch[5] = ~stop_fetch[5];
         @(negedge clk);
      end
      ifc.fetch_ready = 1'b1;
      @(negedge clk);
      check("t3 vtail", 64'(q_vtail_incr), 64'd1 << 5);
      check("t3 valid drop", 64'(ifc.fetch_valid), 64'd0);
      check("t3 outstanding", 64'(outstanding), 64'd1);
      stop_fetch = '0;

      // 4: return of slot 7 coincides with handshake of slot 8
      do_reset();
      wf_valid        = 40'(1) << 7;
      ifc.fetch_ready = 1'b1;
      expect_grant("t4 g7", 7);
      ifc.fetch_ready = 1'b0;
      wf_valid        = (40'(1) << 7) | (40'(1) << 8);
      wait_valid("t4 req8");
      check("t4 id", 64'(ifc.fetch_wf_id), 64'd8);
      ifc.fetch_ready = 1'b1;
      man_id          = 6'd7;
      man_v           = 1'b1;
      wf_valid        = '0;
      @(negedge clk);
      man_v = 1'b0;
      check("t4 outstanding", 64'(outstanding), 64'd1);
      check("t4 pending7", 64'(dut.pending_q[7]), 64'd0);
      check("t4 pending8", 64'(dut.pending_q[8]), 64'd1);
      check("t4 vtail", 64'(q_vtail_incr), 64'd1 << 8);
      check("t4 err", 64'(err_spurious_ret), 64'd0);

      // 5: spurious returns (non-pending slot, then out-of-range id)
      man_id = 6'd9;
      man_v  = 1'b1;
      @(negedge clk);
      man_v = 1'b0;
      check("t5 err set", 64'(err_spurious_ret), 64'd1);
      check("t5 outstanding", 64'(outstanding), 64'd1);
      man_id = 6'd45;
      man_v  = 1'b1;
      @(negedge clk);
      man_v = 1'b0;
      check("t5 range outstanding", 64'(outstanding), 64'd1);
      repeat (3) @(negedge clk);
      check("t5 err sticky", 64'(err_spurious_ret), 64'd1);

      // 6: asynchronous reset in the middle of a request
      ifc.fetch_ready = 1'b0;
      wf_valid        = 40'(1) << 4;
      wait_valid("t6 req");
      check("t6 id", 64'(ifc.fetch_wf_id), 64'd4);
      #2;
      rst = 1'b0;
      #1;
      check("t6 async valid", 64'(ifc.fetch_valid), 64'd0);
      check("t6 async outstanding", 64'(outstanding), 64'd0);
      check("t6 async err", 64'(err_spurious_ret), 64'd0);
      check("t6 async pending", 64'(dut.pending_q), 64'd0);
      @(negedge clk);
      rst             = 1'b1;
`ifdef WQ_FETCH_ARB_PERF_EN
      check("t6 perf grants", 64'(perf_grants), 64'd0);
`endif
      wf_valid        = '1;
      ifc.fetch_ready = 1'b1;
      expect_grant("t6 first", 0);
      expect_grant("t6 second", 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
